// File: rtl/crc_serializer.sv
// crc_serializer: sends a packet LSB-first, then the inverted CRC5/CRC16 of its non-PID bits MSB-first
// Ports: clock, reset (async, active-high); pkt_ready/pkt_in/pkt_len/crc_mode form the load request;
//        bs_ready is the downstream accept; out_bit/crc_sending carry the serial stream;
//        busy (not IDLE), done (pulse after last transfer), err (pulse on rejected load).
// Macro CRC_SERIALIZER_CRC16_EN adds CRC16 mode; without it crc_mode 2'b10 is rejected.
module crc_serializer #(
   parameter int MAX_LEN = 100,
   parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pkt_ready,
   input  logic [MAX_LEN-1:0] pkt_in,
   input  logic [LEN_W-1:0]   pkt_len,
   input  logic [1:0]         crc_mode,
   input  logic               bs_ready,
   output logic               out_bit,
   output logic               crc_sending,
   output logic               busy,
   output logic               done,
   output logic               err
);
`ifdef CRC_SERIALIZER_CRC16_EN
   localparam int CW = 16;
`else
   localparam int CW = 5;
`endif
   typedef enum logic [1:0] {IDLE, PID, DATA, CRC} state_t;
   state_t state, state_next;
   logic [MAX_LEN-1:0] shreg;
   logic [LEN_W-1:0] len, cnt;
   logic [1:0] mode;
   logic [CW-1:0] crc, crc_upd, crc_init;
   logic [4:0] c5;
   logic mode_ok, legal, load, xfer, last_bit, crc_last, fin, crc_msb;
   assign c5 = {crc[3:0], 1'b0} ^ ({5{shreg[0] ^ crc[4]}} & 5'h05);
`ifdef CRC_SERIALIZER_CRC16_EN
   assign mode_ok = crc_mode != 2'b11;
   assign crc_upd = (mode == 2'b10) ? ({crc[14:0], 1'b0} ^ ({16{shreg[0] ^ crc[15]}} & 16'h8005)) : {11'd0, c5};
   assign crc_msb = (mode == 2'b10) ? crc[15] : crc[4];
   assign crc_init = (crc_mode == 2'b10) ? 16'hFFFF : 16'h001F;
`else
   assign mode_ok = crc_mode != 2'b11 && crc_mode != 2'b10;
   assign crc_upd = c5;
   assign crc_msb = crc[4];
   assign crc_init = 5'h1F;
`endif
   assign legal = pkt_len >= LEN_W'(8) && pkt_len <= LEN_W'(MAX_LEN) && mode_ok
                  && (crc_mode != 2'b00 || pkt_len == LEN_W'(8));
   assign load = state == IDLE && pkt_ready && legal;
   assign crc_sending = state != IDLE;
   assign busy = state != IDLE;
   assign xfer = crc_sending && bs_ready;
   // cnt counts packet bits across PID and DATA, then restarts for the CRC bits
   assign last_bit = cnt == len - 1'b1;
   assign crc_last = cnt == ((mode == 2'b10) ? LEN_W'(15) : LEN_W'(4));
   assign out_bit = (state == CRC) ? ~crc_msb : crc_sending & shreg[0];
   // any exit to IDLE from a sending state is the final transfer
   assign fin = state != IDLE && state_next == IDLE;
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_next;
   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = load ? PID : IDLE;
         PID:  if (xfer && last_bit) state_next = (mode == 2'b00) ? IDLE : CRC;
               else if (xfer && cnt == LEN_W'(7)) state_next = DATA;
         DATA: if (xfer && last_bit) state_next = CRC;
         CRC:  if (xfer && crc_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         shreg <= '0;
         len <= '0;
         mode <= '0;
         cnt <= '0;
         crc <= '0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= fin;
         err <= state == IDLE && pkt_ready && !legal;
         if (load) begin
            shreg <= pkt_in;
            len <= pkt_len;
            mode <= crc_mode;
            cnt <= '0;
            crc <= crc_init;
         end else if (xfer && state == CRC) begin
            crc <= crc << 1;
            cnt <= cnt + 1'b1;
         end else if (xfer) begin
            shreg <= shreg >> 1;
            cnt <= last_bit ? '0 : cnt + 1'b1;
            if (state == DATA) crc <= crc_upd;
         end
      end
endmodule

// File: tb/tb_crc_serializer.sv
// tb_crc_serializer: randomized and directed checks of crc_serializer against a bit-queue model
module tb_crc_serializer;
   localparam int MAX_LEN = 100;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   logic clock, reset, pkt_ready, bs_ready;
   logic [MAX_LEN-1:0] pkt_in;
   logic [LEN_W-1:0] pkt_len;
   logic [1:0] crc_mode;
   logic out_bit, crc_sending, busy, done, err;
   crc_serializer #(.MAX_LEN(MAX_LEN)) dut (
      .clock(clock), .reset(reset), .pkt_ready(pkt_ready), .pkt_in(pkt_in),
      .pkt_len(pkt_len), .crc_mode(crc_mode), .bs_ready(bs_ready), .out_bit(out_bit),
      .crc_sending(crc_sending), .busy(busy), .done(done), .err(err));
   initial clock = 1'b0;
   always #5 clock = ~clock;
   int checks = 0, failures = 0;
   bit q[$];
   bit rec[$];
   bit m_done = 0, m_err = 0;
   logic [15:0] m_r;
   logic [18:0] tok = 19'b0100_0000101_11100001;
   logic [23:0] exp_tok;
   logic [MAX_LEN-1:0] tok_p, p;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", n, a, e);
      end
   endtask
   function automatic logic [15:0] crc_calc(input logic [MAX_LEN-1:0] d, input int len, input int w,
                                            input logic [15:0] poly);
      logic [15:0] mask, r;
      bit top;
      mask = 16'((32'd1 << w) - 1);
      r = mask;
      for (int i = 8; i < len; i++) begin
         top = r[w-1] ^ d[i];
         r = ((r << 1) & mask) ^ (top ? poly : 16'd0);
      end
      return r;
   endfunction
   function automatic bit legal_req(input int len, input logic [1:0] m);
      bit has16;
`ifdef CRC_SERIALIZER_CRC16_EN
      has16 = 1;
`else
      has16 = 0;
`endif
      return len >= 8 && len <= MAX_LEN && m != 2'b11 && (m != 2'b00 || len == 8) && (m != 2'b10 || has16);
   endfunction
   // model: expected serial stream as a queue of bits; front is the bit on the wire
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         q.delete();
         m_done = 0;
         m_err = 0;
      end else begin
         m_done = 0;
         m_err = 0;
         if (q.size() > 0) begin
            if (bs_ready) begin
               rec.push_back(out_bit);
               void'(q.pop_front());
               if (q.size() == 0) m_done = 1;
            end
         end else if (pkt_ready) begin
            if (legal_req(int'(pkt_len), crc_mode)) begin
               for (int i = 0; i < int'(pkt_len); i++) q.push_back(pkt_in[i]);
               if (crc_mode == 2'b01) begin
                  m_r = crc_calc(pkt_in, int'(pkt_len), 5, 16'h0005);
                  for (int i = 4; i >= 0; i--) q.push_back(~m_r[i]);
               end
               if (crc_mode == 2'b10) begin
                  m_r = crc_calc(pkt_in, int'(pkt_len), 16, 16'h8005);
                  for (int i = 15; i >= 0; i--) q.push_back(~m_r[i]);
               end
            end else m_err = 1;
         end
      end
   end
   always @(negedge clock)
      if (!reset) begin
         chk("crc_sending", crc_sending, q.size() > 0);
         chk("busy", busy, q.size() > 0);
         if (q.size() > 0) chk("out_bit", out_bit, q[0]);
         chk("done", done, m_done);
         chk("err", err, m_err);
      end
   task automatic load(input logic [MAX_LEN-1:0] d, input int len, input logic [1:0] m);
      pkt_in = d;
      pkt_len = LEN_W'(len);
      crc_mode = m;
      pkt_ready = 1;
      @(negedge clock);
      #1 pkt_ready = 0;
   endtask
   task automatic run(input int mode);
      int st = 0;
      bit ok = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         if (!busy) begin
            ok = 1;
            break;
         end
         #1;
         if (mode == 1) bs_ready = $urandom_range(0, 3) != 0;
         else if (mode == 2 && ((rec.size() == 10 && st == 0) || (rec.size() == 21 && st == 1))) begin
            bs_ready = 0;
            st++;
         end else bs_ready = 1;
      end
      chk("run_finished", ok, 1);
      #1 bs_ready = 1;
      @(negedge clock);
      #1;
   endtask
   task automatic chk_stream(input string n, input logic [23:0] e);
      logic [23:0] a = '0;
      chk({n, "_len"}, rec.size(), 24);
      for (int i = 0; i < rec.size() && i < 24; i++) a[i] = rec[i];
      chk(n, a, e);
   endtask
   initial begin
      #5000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      reset = 1; pkt_ready = 0; pkt_in = '0; pkt_len = '0; crc_mode = '0; bs_ready = 1;
      tok_p = '0;
      tok_p[18:0] = tok;
      exp_tok = {5'b10000, tok};
      repeat (2) @(negedge clock);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_sending", crc_sending, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      #1 reset = 0;
      chk("model_crc5_token", crc_calc(tok_p, 19, 5, 16'h0005), 16'h001E);
      @(negedge clock);
      #1;
      rec.delete();
      load(tok_p, 19, 2'b01);
      run(0);
      chk_stream("token", exp_tok);
      rec.delete();
      load(tok_p, 19, 2'b01);
      run(2);
      chk_stream("token_stall", exp_tok);
      p = '0;
      p[7:0] = 8'hC3;
      rec.delete();
      load(p, 8, 2'b10);
`ifdef CRC_SERIALIZER_CRC16_EN
      run(0);
      chk_stream("data0", {16'h0000, 8'hC3});
`else
      chk("data0_err", err, 1);
      chk("data0_busy", busy, 0);
      run(0);
      chk("data0_nobits", rec.size(), 0);
`endif
      p[7:0] = 8'hA5;
      rec.delete();
      load(p, 8, 2'b00);
      run(0);
      chk("handshake_len", rec.size(), 8);
      for (int k = 0; k < 4; k++) begin
         load(tok_p, (k == 0) ? 7 : (k == 1) ? MAX_LEN + 1 : 19, (k == 2) ? 2'b11 : (k == 3) ? 2'b00 : 2'b01);
         chk("illegal_err", err, 1);
         chk("illegal_busy", busy, 0);
         run(0);
      end
      rec.delete();
      load(tok_p, 19, 2'b01);
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (rec.size() >= 12) break;
      end
      chk("reset_point", rec.size(), 12);
      #1 reset = 1;
      #1;
      chk("mid_rst_out_bit", out_bit, 0);
      chk("mid_rst_sending", crc_sending, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      @(negedge clock);
      #1 reset = 0;
      @(negedge clock);
      #1 rec.delete();
      load(tok_p, 19, 2'b01);
      run(0);
      chk_stream("after_reset", exp_tok);
      for (int i = 0; i < MAX_LEN; i++) p[i] = 1'($urandom_range(0, 1));
      load(p, 30, 2'b01);
      for (int c = 0; c < 500; c++) begin
         @(negedge clock);
         if (done) break;
      end
      chk("b2b_done_seen", done, 1);
      #1 load(tok_p, 19, 2'b01);
      chk("b2b_sending", crc_sending, 1);
      chk("b2b_first_bit", out_bit, 1);
      rec.delete();
      run(0);
      chk_stream("b2b_second", exp_tok);
      for (int n = 0; n < 40; n++) begin
         int len;
         logic [1:0] m;
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(5, MAX_LEN + 3) : $urandom_range(8, MAX_LEN);
         m = 2'($urandom_range(0, 3));
         if (m == 2'b00 && $urandom_range(0, 1) == 1) len = 8;
         for (int i = 0; i < MAX_LEN; i++) p[i] = 1'($urandom_range(0, 1));
         load(p, len, m);
         run(1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
